// File: rtl/periph_xbar_rr_if.sv
// Bus bundle of periph_xbar_rr: initiator-side request/response and target-side request/response.
// The crossbar connects through the slave modport; the initiators and targets around it use master.
interface periph_xbar_rr_if #(
    parameter int unsigned N_MASTER   = 4,
    parameter int unsigned N_SLAVE    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ID_WIDTH = N_MASTER;

    logic [N_MASTER-1:0]                 data_req_i;
    logic [N_MASTER-1:0]                 data_wen_i;
    logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
    logic [N_MASTER-1:0]                 data_gnt_o;
    logic [N_MASTER-1:0]                 data_r_valid_o;
    logic [N_MASTER-1:0]                 data_r_opc_o;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_r_rdata_o;

    logic [N_SLAVE-1:0]                  data_req_o;
    logic [N_SLAVE-1:0]                  data_wen_o;
    logic [N_SLAVE-1:0][ADDR_WIDTH-1:0]  data_add_o;
    logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  data_wdata_o;
    logic [N_SLAVE-1:0][BE_WIDTH-1:0]    data_be_o;
    logic [N_SLAVE-1:0][ID_WIDTH-1:0]    data_ID_o;
    logic [N_SLAVE-1:0]                  data_gnt_i;
    logic [N_SLAVE-1:0]                  data_r_valid_i;
    logic [N_SLAVE-1:0]                  data_r_opc_i;
    logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  data_r_rdata_i;
    logic [N_SLAVE-1:0][ID_WIDTH-1:0]    data_r_ID_i;

    modport master (
        output data_req_i, data_wen_i, data_add_i, data_wdata_i, data_be_i,
        input  data_gnt_o, data_r_valid_o, data_r_opc_o, data_r_rdata_o,
        input  data_req_o, data_wen_o, data_add_o, data_wdata_o, data_be_o, data_ID_o,
        output data_gnt_i, data_r_valid_i, data_r_opc_i, data_r_rdata_i, data_r_ID_i
    );

    modport slave (
        input  data_req_i, data_wen_i, data_add_i, data_wdata_i, data_be_i,
        output data_gnt_o, data_r_valid_o, data_r_opc_o, data_r_rdata_o,
        output data_req_o, data_wen_o, data_add_o, data_wdata_o, data_be_o, data_ID_o,
        input  data_gnt_i, data_r_valid_i, data_r_opc_i, data_r_rdata_i, data_r_ID_i
    );
endinterface

// File: rtl/periph_xbar_rr.sv
// Peripheral crossbar: address-field decode, per-target round-robin arbitration, per-master
// outstanding tracking with same-target ordering, and an error responder for unmapped targets.
module periph_xbar_rr #(
    parameter int unsigned N_MASTER   = 4,
    parameter int unsigned N_SLAVE    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROUTE_LSB  = 10,
    parameter int unsigned ROUTE_MSB  = 13,
    parameter int unsigned MAX_OUT    = 2,
    parameter logic [31:0] ERR_RDATA  = 32'hBADACCE5
) (
    input  logic             clk,
    input  logic             rst_n,
    periph_xbar_rr_if.slave  bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ID_WIDTH = N_MASTER;
    localparam int unsigned TGT_W    = ROUTE_MSB - ROUTE_LSB + 1;
    localparam int unsigned MIDX_W   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);
    localparam int unsigned N_PORT   = N_SLAVE + 1;
    localparam int unsigned PORT_W   = $clog2(N_PORT);

    logic [TGT_W-1:0]    tgt        [N_MASTER];
    logic [PORT_W-1:0]   dest       [N_MASTER];
    logic [N_MASTER-1:0] elig;
    logic [CNT_W-1:0]    cnt_q      [N_MASTER];
    logic [TGT_W-1:0]    last_tgt_q [N_MASTER];
    logic [MIDX_W-1:0]   ptr_q      [N_PORT];
    logic [N_PORT-1:0]   win_vld;
    logic [MIDX_W-1:0]   win_idx    [N_PORT];
    logic [N_PORT-1:0]   port_gnt;
    logic [N_MASTER-1:0] multi_src;
    logic                err_valid_q;
    logic [MIDX_W-1:0]   err_idx_q;

    // Master index base+off wrapped modulo N_MASTER (base < N_MASTER, off <= N_MASTER).
    function automatic logic [MIDX_W-1:0] rr_idx(input logic [MIDX_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_MASTER) sum = sum - N_MASTER;
        return MIDX_W'(sum);
    endfunction

    // Decode target port (index N_SLAVE is the error responder) and apply the ordering gate.
    always_comb begin
        for (int m = 0; m < N_MASTER; m++) begin
            tgt[m]  = bus.data_add_i[m][ROUTE_MSB:ROUTE_LSB];
            dest[m] = (32'(tgt[m]) < N_SLAVE) ? PORT_W'(tgt[m]) : PORT_W'(N_SLAVE);
            elig[m] = bus.data_req_i[m] &&
                      ((cnt_q[m] == '0) ||
                       ((tgt[m] == last_tgt_q[m]) && (cnt_q[m] < CNT_W'(MAX_OUT))));
        end
    end

    // Per-port rotating-priority search starting at ptr_q.
    always_comb begin
        logic [MIDX_W-1:0] k;
        k        = '0;
        win_vld  = '0;
        port_gnt = {1'b1, bus.data_gnt_i};
        for (int p = 0; p < N_PORT; p++) begin
            win_idx[p] = '0;
            for (int i = 0; i < N_MASTER; i++) begin
                k = rr_idx(ptr_q[p], 32'(i));
                if (!win_vld[p] && elig[k] && (dest[k] == PORT_W'(p))) begin
                    win_vld[p] = 1'b1;
                    win_idx[p] = k;
                end
            end
        end
    end

    // Forward winners to targets and route grants back.
    always_comb begin
        bus.data_req_o   = '0;
        bus.data_wen_o   = '0;
        bus.data_add_o   = '0;
        bus.data_wdata_o = '0;
        bus.data_be_o    = '0;
        bus.data_ID_o    = '0;
        bus.data_gnt_o   = '0;
        for (int p = 0; p < N_SLAVE; p++) begin
            if (win_vld[p]) begin
                bus.data_req_o[p]            = 1'b1;
                bus.data_wen_o[p]            = bus.data_wen_i[win_idx[p]];
                bus.data_add_o[p]            = ADDR_WIDTH'(bus.data_add_i[win_idx[p]]);
                bus.data_wdata_o[p]          = bus.data_wdata_i[win_idx[p]];
                bus.data_be_o[p]             = BE_WIDTH'(bus.data_be_i[win_idx[p]]);
                bus.data_ID_o[p]             = ID_WIDTH'(1) << win_idx[p];
                bus.data_gnt_o[win_idx[p]]   = bus.data_gnt_i[p];
            end
        end
        if (win_vld[N_SLAVE]) bus.data_gnt_o[win_idx[N_SLAVE]] = 1'b1;
    end

    // Response routing by one-hot ID, error responder merged in; flags colliding sources.
    always_comb begin
        bus.data_r_valid_o = '0;
        bus.data_r_opc_o   = '0;
        bus.data_r_rdata_o = '0;
        multi_src          = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            for (int s = 0; s < N_SLAVE; s++) begin
                if (bus.data_r_valid_i[s] && bus.data_r_ID_i[s][m]) begin
                    multi_src[m]          = multi_src[m] | bus.data_r_valid_o[m];
                    bus.data_r_valid_o[m] = 1'b1;
                    bus.data_r_opc_o[m]   = bus.data_r_opc_i[s];
                    bus.data_r_rdata_o[m] = bus.data_r_rdata_i[s];
                end
            end
            if (err_valid_q && (err_idx_q == MIDX_W'(m))) begin
                multi_src[m]          = multi_src[m] | bus.data_r_valid_o[m];
                bus.data_r_valid_o[m] = 1'b1;
                bus.data_r_opc_o[m]   = 1'b1;
                bus.data_r_rdata_o[m] = DATA_WIDTH'(ERR_RDATA);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PORT; p++) ptr_q[p] <= '0;
            for (int m = 0; m < N_MASTER; m++) begin
                cnt_q[m]      <= '0;
                last_tgt_q[m] <= '0;
            end
            err_valid_q <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            for (int p = 0; p < N_PORT; p++) begin
                if (win_vld[p] && port_gnt[p]) ptr_q[p] <= rr_idx(win_idx[p], 1);
            end
            err_valid_q <= win_vld[N_SLAVE];
            err_idx_q   <= win_idx[N_SLAVE];
            for (int m = 0; m < N_MASTER; m++) begin
                if (bus.data_gnt_o[m]) last_tgt_q[m] <= tgt[m];
                case ({bus.data_gnt_o[m], bus.data_r_valid_o[m]})
                    2'b10:   cnt_q[m] <= cnt_q[m] + CNT_W'(1);
                    2'b01:   if (cnt_q[m] != '0) cnt_q[m] <= cnt_q[m] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // A stray response is legal after reset, so it only warns; colliding sources are an error.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < N_MASTER; m++) begin
                assert (!multi_src[m])
                    else $error("periph_xbar_rr: multiple response sources for master %0d", m);
                assert (!(bus.data_r_valid_o[m] && (cnt_q[m] == '0)))
                    else $warning("periph_xbar_rr: response to master %0d with nothing outstanding", m);
            end
        end
    end
endmodule

// File: doc/periph_xbar_rr.md
# periph_xbar_rr

Parametrised peripheral crossbar with grant-based flow control. It connects N_MASTER initiators (cores, DMA ports) to N_SLAVE peripheral targets, decoding a slave index from a configurable address field and arbitrating each slave round-robin. It routes responses back by one-hot master ID. Compared with the earlier peripheral crossbar, it adds three things:
- per-master outstanding-transaction tracking with same-target ordering;
- an internal error responder for unmapped addresses;
- fair rotating-priority arbitration.

## Interface
- N_MASTER, 4: number of initiator ports (1..16).
- N_SLAVE, 4: number of mapped target ports (1..16).
- ADDR_WIDTH, 32: master address width.
- DATA_WIDTH, 32: data width; BE_WIDTH = DATA_WIDTH/8.
- ROUTE_LSB, 10 / ROUTE_MSB, 13: address field holding the slave index.
- MAX_OUT, 2: maximum outstanding transactions per master (1..7).
- ERR_RDATA, 32'hBADACCE5: rdata returned by the error responder (zero-extended or truncated to DATA_WIDTH).
- ID_WIDTH = N_MASTER: one-hot master ID.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req_i / data_wen_i  in  N_MASTER  master request; 1 = load, 0 = store.
- data_add_i  in  N_MASTER×ADDR_WIDTH  address.
- data_wdata_i  in  N_MASTER×DATA_WIDTH  write data.
- data_be_i  in  N_MASTER×BE_WIDTH  byte enables.
- data_gnt_o  out  N_MASTER  grant.
- data_r_valid_o / data_r_opc_o  out  N_MASTER  response valid / error flag.
- data_r_rdata_o  out  N_MASTER×DATA_WIDTH  response data.
- data_req_o / data_wen_o  out  N_SLAVE  slave request / type.
- data_add_o  out  N_SLAVE×ADDR_WIDTH  forwarded address, unmodified.
- data_wdata_o  out  N_SLAVE×DATA_WIDTH  forwarded write data.
- data_be_o  out  N_SLAVE×BE_WIDTH  forwarded byte enables.
- data_ID_o  out  N_SLAVE×ID_WIDTH  one-hot ID of the granted master.
- data_gnt_i  in  N_SLAVE  slave grant.
- data_r_valid_i / data_r_opc_i  in  N_SLAVE  slave response valid / error flag.
- data_r_rdata_i  in  N_SLAVE×DATA_WIDTH  slave response data.
- data_r_ID_i  in  N_SLAVE×ID_WIDTH  one-hot ID echoed with the response.

## Operation
- Decode: tgt = add[ROUTE_MSB:ROUTE_LSB].
  - tgt ≥ N_SLAVE selects the error responder (pseudo-slave N_SLAVE).
  - Field wider than needed: upper values decode as unmapped.
- Ordering gate, per master, with state cnt (0..MAX_OUT) and last_tgt:
  - The request is eligible iff cnt == 0, or (tgt == last_tgt and cnt < MAX_OUT).
  - A request that is not eligible is not forwarded and sees gnt = 0.
- Arbitration, per slave:
  - Round-robin among eligible masters targeting that slave, using a priority pointer ptr[s].
  - Winner w is the first requester at or after ptr[s], searching upward modulo N_MASTER.
  - data_req_o[s] = 1 with w's wen/add/wdata/be; data_ID_o[s] = 1<<w.
  - data_gnt_o[w] = data_gnt_i[s]. Losers see gnt = 0.
  - ptr[s] ← (w+1) mod N_MASTER only on a cycle where data_req_o[s] & data_gnt_i[s].
- Error responder:
  - Grants any eligible unmapped request immediately, round-robin with its own pointer, one master per cycle.
  - Next cycle it returns r_valid = 1, opc = 1, rdata = ERR_RDATA to that master.
  - Stores are treated identically.
- Counters, per master:
  - Granted request: cnt+1, last_tgt ← tgt.
  - Response delivered (r_valid_o): cnt−1.
  - Both in the same cycle: cnt unchanged, last_tgt ← tgt.
- Response routing:
  - data_r_valid_o[m] = OR over slaves of (r_valid_i[s] & r_ID_i[s][m]), plus the error responder's valid.
  - rdata and opc are muxed from the source.
  - The ordering gate guarantees at most one source per master per cycle. Multiple sources per master is an illegal input, flagged by an assertion.
- A response whose ID bit hits a master with cnt == 0 is still forwarded; the counter does not underflow (stays 0). An assertion flags it.
- A master may drop req before grant; no state changes.

## Timing
- Request path: combinational. Master req → slave req same cycle; slave gnt → master gnt same cycle.
- Response path from slaves: combinational, zero added latency.
- Error responder latency: exactly 1 cycle after grant.
- Asynchronous reset clears:
  - all ptr to 0;
  - all cnt to 0, last_tgt to 0;
  - error-responder valid to 0.
- Reset outputs, with inputs low: all req_o, gnt_o, r_valid_o, r_opc_o = 0; buses = 0.
- Reset asserted mid-transaction discards all outstanding state. Late slave responses after reset hit the cnt == 0 rule.

## Test plan
- Single master: M0 load to addr 0x0000_0800 (tgt 2), gnt_i[2] = 1, slave responds next cycle with rdata 0x1234 → data_req_o[2] = 1, ID 4'b0001; M0 r_valid = 1, rdata 0x1234; cnt returns to 0.
- Round-robin fairness: M0..M3 hold requests to slave 1 continuously, gnt_i = 1 → grants rotate M0, M1, M2, M3, M0; ptr[1] observed 1, 2, 3, 0.
- Unmapped access: M2 load to tgt 5 with N_SLAVE = 4 → gnt same cycle; next cycle r_valid = 1, opc = 1, rdata = 0xBADACCE5; no slave req asserted.
- Ordering gate: M1 has cnt = 1 toward slave 0 and requests slave 3 → gnt = 0, no req on slave 3 until the slave-0 response arrives. Second request to slave 0 is granted (cnt → 2); third to slave 0 is blocked at MAX_OUT = 2.
- Simultaneous grant and response: M0 cnt = 1 receives a response while a new request is granted → cnt stays 1, last_tgt updated.
- Reset mid-operation: deassert rst_n while cnt = 2 and an error response is pending → next cycle all outputs 0, cnt = 0; a later stray response is forwarded without underflow.
